// File: rtl/apb_slave_responder.sv
// APB completer: decodes one bit of the one-hot Pselx bus, serves a small 32-bit register bank,
// inserts WAIT_CYCLES wait states and flags bad accesses through Pslverr.
module apb_slave_responder #(
    parameter int unsigned SLV_ID      = 0,
    parameter int unsigned NUM_REGS    = 6,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic [31:0] Ctrl_reg
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    localparam logic [9:0] NumRegs  = 10'(NUM_REGS);
    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  idx_q, idx_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] prdata_q, prdata_d;
    // Register 0 is the constant ID, so only indices 1.. hold storage.
    logic [31:0] regs_q [1:NUM_REGS-1];
    logic [31:0] regs_d [1:NUM_REGS-1];

    logic        sel;
    logic [9:0]  idx;
    logic        err;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign sel = Pselx[SLV_ID];
    assign idx = Paddr[11:2];
    assign err = (Paddr[1:0] != 2'b00) | (idx >= NumRegs) | (Pwrite & (idx == 10'd0));
    assign unused_bits = ^{Paddr[31:12], Pselx};

    always_comb begin
        rd_val = '0;
        if (idx == 10'd0) begin
            rd_val = ID_VALUE;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (idx == 10'(i)) rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        prdata_d = prdata_q;
        regs_d   = regs_q;
        unique case (state_q)
            StIdle: begin
                // Penable without a preceding setup phase is not a transfer start.
                if (sel && !Penable) begin
                    state_d  = StAccess;
                    cnt_d    = WaitInit;
                    idx_d    = idx;
                    write_d  = Pwrite;
                    wdata_d  = Pwdata;
                    err_d    = err;
                    prdata_d = (Pwrite || err) ? '0 : rd_val;
                end
            end
            StAccess: begin
                if (!sel) begin
                    state_d  = StIdle;
                    prdata_d = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (Penable) begin
                    state_d  = StIdle;
                    prdata_d = '0;
                    if (write_q && !err_q) begin
                        for (int unsigned i = 1; i < NUM_REGS; i++) begin
                            if (idx_q == 10'(i)) regs_d[i] = wdata_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            prdata_q <= '0;
            for (int unsigned i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
            regs_q   <= regs_d;
        end
    end

    assign Pready   = (state_q == StAccess) && (cnt_q == 4'd0);
    assign Pslverr  = err_q & Pready;
    assign Prdata   = prdata_q;
    assign Ctrl_reg = regs_q[1];

endmodule

// File: tb/tb_apb_slave_responder.sv
// Bench: three responders (one per Pselx bit, differing wait states) on a shared APB bus,
// checked against a register-bank model of each completer.
module tb_apb_slave_responder;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];
    logic [31:0] ctrl [3];

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned wait_c [3] = '{0, 3, 5};
    int unsigned nregs [3]  = '{6, 6, 8};
    logic [31:0] idv [3]    = '{32'hA5B0_0001, 32'hA5B1_0001, 32'hA5B2_0001};
    logic [31:0] mem [3][16];

    always #5 Hclk = ~Hclk;

    apb_slave_responder #(.SLV_ID(0), .NUM_REGS(6), .WAIT_CYCLES(0), .ID_VALUE(32'hA5B0_0001)) u_slv0 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[0]), .Pready(pready[0]),
        .Pslverr(pslverr[0]), .Ctrl_reg(ctrl[0]));
    apb_slave_responder #(.SLV_ID(1), .NUM_REGS(6), .WAIT_CYCLES(3), .ID_VALUE(32'hA5B1_0001)) u_slv1 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[1]), .Pready(pready[1]),
        .Pslverr(pslverr[1]), .Ctrl_reg(ctrl[1]));
    apb_slave_responder #(.SLV_ID(2), .NUM_REGS(8), .WAIT_CYCLES(5), .ID_VALUE(32'hA5B2_0001)) u_slv2 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[2]), .Pready(pready[2]),
        .Pslverr(pslverr[2]), .Ctrl_reg(ctrl[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input int s, input logic wr, input logic [31:0] a);
        int unsigned k;
        k = int'(a[11:2]);
        return (a[1:0] != 2'b00) || (k >= nregs[s]) || (wr && k == 0);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 16; k++) mem[s][k] = '0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 3; s++) begin
            check({tag, "_prdata"}, prdata[s], 32'h0);
            check({tag, "_pready"}, {31'b0, pready[s]}, 32'h0);
            check({tag, "_pslverr"}, {31'b0, pslverr[s]}, 32'h0);
            check({tag, "_ctrl"}, ctrl[s], 32'h0);
        end
    endtask

    // Called just after a rising edge; returns just after the completing edge with the bus idle.
    task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic        err;
        logic [31:0] exp_rd;
        int unsigned k;
        int unsigned last;
        logic        exp_rdy;
        err    = model_err(s, wr, a);
        k      = int'(a[11:2]);
        exp_rd = (wr || err) ? 32'h0 : ((k == 0) ? idv[s] : mem[s][k]);
        last   = wait_c[s] + 1;
        Pselx   = 3'(1 << s);
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = a;
        Pwdata  = d;
        @(posedge Hclk) #1;
        Penable = 1'b1;
        for (int unsigned n = 1; n <= last; n++) begin
            @(negedge Hclk);
            exp_rdy = (n == last);
            check("acc_prdata", prdata[s], exp_rd);
            check("acc_pready", {31'b0, pready[s]}, {31'b0, exp_rdy});
            check("acc_pslverr", {31'b0, pslverr[s]}, {31'b0, exp_rdy & err});
            for (int j = 0; j < 3; j++)
                if (j != s) check("other_pready", {31'b0, pready[j]}, 32'h0);
            if (n < last) @(posedge Hclk) #1;
        end
        @(posedge Hclk) #1;
        Pselx   = 3'b000;
        Penable = 1'b0;
        if (wr && !err) mem[s][k] = d;
        check("done_pready", {31'b0, pready[s]}, 32'h0);
        check("done_prdata", prdata[s], 32'h0);
        for (int j = 0; j < 3; j++) check("ctrl_reg", ctrl[j], mem[j][1]);
    endtask

    initial begin
        logic [31:0] a;
        int          s;
        logic        wr;
        model_reset();
        Hresetn = 1'b0;
        Pselx   = 3'b000;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = '0;
        Pwdata  = '0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge Hclk);
        #1 Hresetn = 1'b1;

        // Zero-wait write/read of the control register.
        xfer(0, 1'b1, 32'h0000_0004, 32'h1234_5678);
        xfer(0, 1'b0, 32'h0000_0004, 32'h0);
        // Three wait states, ID read.
        xfer(1, 1'b0, 32'h0000_0000, 32'h0);
        // Error writes: ID register, out of range, unaligned.
        for (int s2 = 0; s2 < 3; s2++) begin
            xfer(s2, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
            xfer(s2, 1'b1, 32'h0000_0018, 32'hFFFF_FFFF);
            xfer(s2, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF);
            xfer(s2, 1'b0, 32'h0000_0000, 32'h0);
        end
        // Back-to-back write then read of register 2.
        xfer(1, 1'b1, 32'h0000_0008, 32'hCAFE_0008);
        xfer(1, 1'b0, 32'h0000_0008, 32'h0);
        xfer(2, 1'b1, 32'h0000_0004, 32'h0BAD_F00D);

        // Penable without setup phase is ignored.
        Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h4; Pwdata = 32'h5555_5555;
        repeat (2) begin
            @(negedge Hclk);
            check("nosetup_pready", {31'b0, pready[0]}, 32'h0);
        end
        @(posedge Hclk) #1;
        Pselx = 3'b000; Penable = 1'b0;
        check("nosetup_ctrl", ctrl[0], mem[0][1]);

        // Master abort after two access cycles of a write to register 3.
        xfer(2, 1'b1, 32'h0000_000C, 32'h3333_3333);
        Pselx = 3'b100; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'hC; Pwdata = 32'hDEAD_BEEF;
        @(posedge Hclk) #1;
        Penable = 1'b1;
        repeat (2) begin
            @(negedge Hclk);
            check("abort_pready", {31'b0, pready[2]}, 32'h0);
            @(posedge Hclk) #1;
        end
        Pselx = 3'b000; Penable = 1'b0;
        repeat (2) begin
            @(negedge Hclk);
            check("abort_idle_pready", {31'b0, pready[2]}, 32'h0);
        end
        @(posedge Hclk) #1;
        xfer(2, 1'b0, 32'h0000_000C, 32'h0);

        // Reset in the middle of an access phase.
        Pselx = 3'b100; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'h7777_7777;
        @(posedge Hclk) #1;
        Penable = 1'b1;
        @(negedge Hclk);
        Hresetn = 1'b0;
        #1;
        model_reset();
        check_all_zero("midreset");
        Pselx = 3'b000; Penable = 1'b0;
        @(posedge Hclk) #1;
        Hresetn = 1'b1;
        xfer(2, 1'b0, 32'h0000_0010, 32'h0);
        xfer(0, 1'b0, 32'h0000_0004, 32'h0);

        // Randomized traffic, optional idle gaps between transfers.
        for (int t = 0; t < 60; t++) begin
            s  = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 8)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            xfer(s, wr, a, $urandom());
            if ($urandom_range(0, 1) == 1) @(posedge Hclk) #1;
        end
        for (int s2 = 0; s2 < 3; s2++)
            for (int k = 0; k < 8; k++) xfer(s2, 1'b0, 32'(k) << 2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_responder.md
Name: apb_slave_responder

Overview:
- APB completer (slave) at the peripheral end of the AHB-to-APB bridge.
- Decodes its own bit of the 3-bit one-hot Pselx bus and serves a small 32-bit register bank.
- Inserts a programmable number of wait states via Pready and flags bad accesses via Pslverr.
- Up to three instances (one per Pselx bit) sit behind the bridge; register 1 is exported as a control word.

Parameters:
- SLV_ID, 0, which Pselx bit (0..2) selects this instance.
- NUM_REGS, 6, number of implemented 32-bit registers (2..16); index 0 is read-only ID.
- WAIT_CYCLES, 0, access-phase wait states (0..15); 0 = zero-wait, safe for masters that ignore Pready.
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.

Ports:
- Hclk  input  1  APB/system clock, rising edge.
- Hresetn  input  1  reset; asynchronous, active-low.
- Pselx  input  3  one-hot peripheral select from the bridge.
- Penable  input  1  APB enable (access phase).
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address; only Paddr[11:0] decoded.
- Pwdata  input  32  write data.
- Prdata  output  32  read data.
- Pready  output  1  transfer complete.
- Pslverr  output  1  error response, valid only when Pready=1.
- Ctrl_reg  output  32  current contents of register 1.

Behaviour:
- sel = Pselx[SLV_ID]; idx = Paddr[11:2].
- err = (Paddr[1:0] != 0) | (idx >= NUM_REGS) | (Pwrite & idx == 0).
- Async reset (Hresetn=0): state=IDLE, wait counter=0, all registers=0 (reg0 reads ID_VALUE), Prdata=0, Pready=0, Pslverr=0, Ctrl_reg=0. Reset mid-transfer abandons it; no write occurs.
- FSM states: IDLE, ACCESS.
- IDLE: on sel & ~Penable (setup phase), latch addr/Pwrite/Pwdata/err, load cnt=WAIT_CYCLES, go ACCESS. Penable=1 seen in IDLE (no setup) is ignored and the FSM stays in IDLE.
- ACCESS:
  - Pready = (cnt==0), combinational from state and cnt; Pready=0 in IDLE.
  - Each cycle with cnt>0, cnt decrements.
  - When cnt==0 & sel & Penable, the transfer completes at that edge. A write with latched err=0 updates the register; a write with err=1 leaves all registers unchanged. FSM returns to IDLE.
  - Back-to-back: a new setup phase on the cycle after completion is accepted from IDLE. No idle cycle is required between transfers.
  - If sel drops in ACCESS before completion (master abort): go IDLE, no write, Pready stays 0.
- Latency: WAIT_CYCLES+1 cycles from the setup edge to the completing edge. With WAIT_CYCLES=0, completion happens on the first access-phase cycle.
- Prdata:
  - Registered, loaded on the setup edge with the register value, ID_VALUE for idx 0, or 0 if err.
  - Held through ACCESS; cleared to 0 on the completing edge.
  - For writes it is 0.
  - A write to register k is visible to a read whose setup phase follows the write's completion.
- Pslverr = latched err & Pready; 0 otherwise.
- Ctrl_reg is driven directly from register 1 and updates the cycle after the write completes.
- Pselx with multiple bits set: this block responds only to its own bit, with no checking of the others.

Test Plan:
- WAIT_CYCLES=0, write 32'h1234_5678 to Paddr=0x004, then read 0x004 -> Pready=1 in the first access cycle, Pslverr=0, Ctrl_reg=32'h1234_5678 after completion, Prdata=32'h1234_5678 during the read access.
- WAIT_CYCLES=3, read 0x000 -> Pready low for 3 access cycles, high on the 4th; Prdata=32'hA5B0_0001 from the access phase onward.
- Write 32'hFFFF_FFFF to 0x000 (ID), 0x018 (idx 6 ≥ NUM_REGS), and 0x006 (unaligned) -> each completes with Pslverr=1 and no register changes; reading 0x000 returns ID_VALUE.
- Back-to-back write 0x008 then read 0x008 with no idle between -> the read returns the written value; each transfer has exactly WAIT_CYCLES+1 access cycles.
- WAIT_CYCLES=5, drop Pselx after 2 access cycles of a write to 0x00C -> FSM returns to IDLE, Pready never asserted, register 3 unchanged. Assert Hresetn=0 mid-access of another write -> all outputs 0 immediately, no write occurs.
- SLV_ID=1, drive Pselx=3'b001 and 3'b100 transfers -> no response (Pready=0, registers unchanged); Pselx=3'b010 -> normal response.
